best_time_keeper: RTL and testbench

Lap-record stage directly downstream of the six-digit BCD race-time counter. On a capture pulse it snapshots the running time and compares it digit-serially, most significant digit first, against the stored best time. It then updates the best time if the new time is a record and reports the result to the HUD/score logic. Its outputs feed the best-time display and the "new record" banner.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/best_time_keeper_cmp.sv | 15 +
 rtl/best_time_keeper.sv | 182 ++++++++++++++++++
 tb/tb_best_time_keeper.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD time types and the lap-record FSM state encoding.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX         = 4'd9;
   localparam int         NUM_TIME_DIGITS = 6;

   // Element [0] is the least significant digit (seconds units).
   typedef bcd_digit_t [NUM_TIME_DIGITS-1:0] bcd_time_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      UPDATE  = 2'd2
   } keeper_state_t;

endpackage

// File: rtl/best_time_keeper_cmp.sv
// Combinational magnitude compare of one BCD digit (raw 4-bit unsigned).
module bcd_digit_cmp
   import bcd_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   output logic       lt,
   output logic       gt
);

   // Codes above 9 are compared as plain binary; no correction is applied.
   assign lt = (a < b);
   assign gt = (a > b);

endmodule

// File: rtl/best_time_keeper.sv
// Lap-record keeper: snapshots the race time on capture, compares it
// MSD-first against the stored best over six cycles, then updates the best.
module best_time_keeper
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS    = 6,
   parameter bit RECORD_ON_TIE = 1'b0
)(
   input  logic       clk,
   input  logic       resetN,
   input  logic       capture,
   input  logic       clear_bestN,
   input  logic [3:0] count1,
   input  logic [3:0] count2,
   input  logic [3:0] count3,
   input  logic [3:0] count4,
   input  logic [3:0] count5,
   input  logic [3:0] count6,
   output logic [3:0] best1,
   output logic [3:0] best2,
   output logic [3:0] best3,
   output logic [3:0] best4,
   output logic [3:0] best5,
   output logic [3:0] best6,
   output logic [3:0] last1,
   output logic [3:0] last2,
   output logic [3:0] last3,
   output logic [3:0] last4,
   output logic [3:0] last5,
   output logic [3:0] last6,
   output logic       has_best,
   output logic       busy,
   output logic       done,
   output logic       new_record
);

   keeper_state_t state_r;
   keeper_state_t next_state_s;

   bcd_time_t  snap_r;
   bcd_time_t  best_r;
   bcd_time_t  last_r;
   bcd_time_t  count_s;
   logic [2:0] idx_r;
   logic       less_r;
   logic       decided_r;
   logic       has_best_r;
   logic       busy_r;
   logic       done_r;
   logic       new_record_r;

   bcd_digit_t cmp_snap_s;
   bcd_digit_t cmp_best_s;
   logic       cmp_lt_s;
   logic       cmp_gt_s;
   logic       record_s;

   assign count_s = {count6, count5, count4, count3, count2, count1};

   assign {best6, best5, best4, best3, best2, best1} = best_r;
   assign {last6, last5, last4, last3, last2, last1} = last_r;
   assign has_best   = has_best_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign new_record = new_record_r;

   // Select the digit pair addressed by the index (6 = MSD down to 1 = LSD).
   always_comb begin
      cmp_snap_s = 4'd0;
      cmp_best_s = 4'd0;
      case (idx_r)
         3'd1: begin cmp_snap_s = snap_r[0]; cmp_best_s = best_r[0]; end
         3'd2: begin cmp_snap_s = snap_r[1]; cmp_best_s = best_r[1]; end
         3'd3: begin cmp_snap_s = snap_r[2]; cmp_best_s = best_r[2]; end
         3'd4: begin cmp_snap_s = snap_r[3]; cmp_best_s = best_r[3]; end
         3'd5: begin cmp_snap_s = snap_r[4]; cmp_best_s = best_r[4]; end
         3'd6: begin cmp_snap_s = snap_r[5]; cmp_best_s = best_r[5]; end
         default: begin cmp_snap_s = 4'd0; cmp_best_s = 4'd0; end
      endcase
   end

   bcd_digit_cmp u_cmp (
      .a  (cmp_snap_s),
      .b  (cmp_best_s),
      .lt (cmp_lt_s),
      .gt (cmp_gt_s)
   );

   // Without a stored best any time is a record; ties count only if enabled.
   assign record_s = !has_best_r || less_r || (RECORD_ON_TIE && !decided_r);

   // FSM state register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: fixed six compare cycles, then a single update cycle.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (capture) begin
               next_state_s = COMPARE;
            end else begin
               next_state_s = IDLE;
            end
         end
         COMPARE: begin
            if (idx_r == 3'd1) begin
               next_state_s = UPDATE;
            end else begin
               next_state_s = COMPARE;
            end
         end
         UPDATE:  next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Datapath: snapshot/last capture, digit-serial flags, best update and pulses.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         snap_r       <= {NUM_TIME_DIGITS{4'd0}};
         best_r       <= {NUM_TIME_DIGITS{4'd0}};
         last_r       <= {NUM_TIME_DIGITS{4'd0}};
         idx_r        <= 3'd0;
         less_r       <= 1'b0;
         decided_r    <= 1'b0;
         has_best_r   <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         new_record_r <= 1'b0;
      end else begin
         done_r       <= 1'b0;
         new_record_r <= 1'b0;
         busy_r       <= (next_state_s != IDLE);
         case (state_r)
            IDLE: begin
               // Capture has priority; a coincident clear is dropped.
               if (capture) begin
                  snap_r    <= count_s;
                  last_r    <= count_s;
                  idx_r     <= 3'(NUM_DIGITS);
                  less_r    <= 1'b0;
                  decided_r <= 1'b0;
               end else if (!clear_bestN) begin
                  best_r     <= {NUM_TIME_DIGITS{4'd0}};
                  has_best_r <= 1'b0;
               end
            end
            COMPARE: begin
               // The first differing digit (from the MSD) decides the result.
               if (!decided_r) begin
                  if (cmp_lt_s) begin
                     less_r    <= 1'b1;
                     decided_r <= 1'b1;
                  end else if (cmp_gt_s) begin
                     decided_r <= 1'b1;
                  end
               end
               idx_r <= idx_r - 3'd1;
            end
            UPDATE: begin
               done_r       <= 1'b1;
               new_record_r <= record_s;
               if (record_s) begin
                  best_r     <= snap_r;
                  has_best_r <= 1'b1;
               end
            end
            default: begin
               idx_r <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_best_time_keeper.sv
// Directed, table-driven bench for best_time_keeper. Two instances share the
// stimulus: dut0 treats ties as non-records, dut1 treats ties as records.
module tb_best_time_keeper;

   logic        clk;
   logic        resetN;
   logic        capture;
   logic        clear_bestN;
   logic [23:0] count;

   wire  [23:0] best0, last0, best1, last1;
   wire         hb0, busy0, done0, nr0;
   wire         hb1, busy1, done1, nr1;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [23:0] t;
      logic        pre_clear;
      logic        clr_with_cap;
      logic        exp_rec;
      logic        exp_rec_tie;
      logic [23:0] exp_best;
   } vec_t;

   vec_t vecs[7];

   best_time_keeper #(.NUM_DIGITS(6), .RECORD_ON_TIE(1'b0)) dut0 (
      .clk(clk), .resetN(resetN), .capture(capture), .clear_bestN(clear_bestN),
      .count1(count[3:0]), .count2(count[7:4]), .count3(count[11:8]),
      .count4(count[15:12]), .count5(count[19:16]), .count6(count[23:20]),
      .best1(best0[3:0]), .best2(best0[7:4]), .best3(best0[11:8]),
      .best4(best0[15:12]), .best5(best0[19:16]), .best6(best0[23:20]),
      .last1(last0[3:0]), .last2(last0[7:4]), .last3(last0[11:8]),
      .last4(last0[15:12]), .last5(last0[19:16]), .last6(last0[23:20]),
      .has_best(hb0), .busy(busy0), .done(done0), .new_record(nr0)
   );

   best_time_keeper #(.NUM_DIGITS(6), .RECORD_ON_TIE(1'b1)) dut1 (
      .clk(clk), .resetN(resetN), .capture(capture), .clear_bestN(clear_bestN),
      .count1(count[3:0]), .count2(count[7:4]), .count3(count[11:8]),
      .count4(count[15:12]), .count5(count[19:16]), .count6(count[23:20]),
      .best1(best1[3:0]), .best2(best1[7:4]), .best3(best1[11:8]),
      .best4(best1[15:12]), .best5(best1[19:16]), .best6(best1[23:20]),
      .last1(last1[3:0]), .last2(last1[7:4]), .last3(last1[11:8]),
      .last4(last1[15:12]), .last5(last1[19:16]), .last6(last1[23:20]),
      .has_best(hb1), .busy(busy1), .done(done1), .new_record(nr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // One capture from IDLE; observes 12 cycles after the accepting edge.
   // disturb: counts change during COMPARE and a second capture hits edge N+3.
   task automatic run_capture(input vec_t v, input logic disturb);
      @(negedge clk);
      count       = v.t;
      capture     = 1'b1;
      clear_bestN = v.clr_with_cap ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      capture     = 1'b0;
      clear_bestN = 1'b1;
      check("busy_after_capture", {31'd0, busy0}, 32'd1);
      check("last_after_capture", {8'd0, last0}, {8'd0, v.t});
      if (v.clr_with_cap) begin
         check("clear_dropped_has_best", {31'd0, hb0}, 32'd1);
      end
      if (disturb) begin
         count = 24'h999999;
      end
      for (int i = 1; i <= 12; i++) begin
         if (disturb && i == 2) begin
            capture = 1'b1;
            count   = 24'h000001;
         end
         @(negedge clk);
         if (disturb && i == 3) begin
            capture = 1'b0;
         end
         check($sformatf("busy_c%0d", i), {31'd0, busy0}, {31'd0, (i < 7)});
         check($sformatf("done_c%0d", i), {31'd0, done0}, {31'd0, (i == 7)});
         check($sformatf("nr_c%0d", i), {31'd0, nr0}, {31'd0, (i == 7) && v.exp_rec});
         if (i == 7) begin
            check("nr_tie_dut", {31'd0, nr1}, {31'd0, v.exp_rec_tie});
            check("done_tie_dut", {31'd0, done1}, 32'd1);
         end
      end
      check("best_after", {8'd0, best0}, {8'd0, v.exp_best});
      check("best_after_tie_dut", {8'd0, best1}, {8'd0, v.exp_best});
      check("has_best_after", {31'd0, hb0}, 32'd1);
      check("last_after", {8'd0, last0}, {8'd0, v.t});
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear_bestN = 1'b0;
      @(negedge clk);
      clear_bestN = 1'b1;
      check("clear_best", {8'd0, best0}, 32'd0);
      check("clear_has_best", {31'd0, hb0}, 32'd0);
      check("clear_has_best_tie_dut", {31'd0, hb1}, 32'd0);
   endtask

   initial begin
      vec_t dv;
      n_cmp = 0;
      n_bad = 0;
      resetN      = 1'b0;
      capture     = 1'b0;
      clear_bestN = 1'b1;
      count       = 24'h000000;

      //        time        pre  clr  rec   tie   best
      vecs[0] = '{24'h000123, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000123};
      vecs[1] = '{24'h000059, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000059};
      vecs[2] = '{24'h000100, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000059};
      vecs[3] = '{24'h000059, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000059};
      vecs[4] = '{24'h100000, 1'b1, 1'b0, 1'b1, 1'b1, 24'h100000};
      vecs[5] = '{24'h099999, 1'b0, 1'b0, 1'b1, 1'b1, 24'h099999};
      vecs[6] = '{24'h100000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h099999};

      repeat (3) @(negedge clk);
      check("reset_best", {8'd0, best0}, 32'd0);
      check("reset_last", {8'd0, last0}, 32'd0);
      check("reset_flags", {28'd0, hb0, busy0, done0, nr0}, 32'd0);
      resetN = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 7; k++) begin
         if (vecs[k].pre_clear) begin
            do_clear();
         end
         run_capture(vecs[k], 1'b0);
      end

      // Counts disturbed mid-compare and a capture while busy: original snapshot wins.
      dv = '{24'h000500, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000500};
      run_capture(dv, 1'b1);

      // Reset in the middle of COMPARE aborts and loses the stored best.
      @(negedge clk);
      count   = 24'h000001;
      capture = 1'b1;
      @(negedge clk);
      capture = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midcmp_busy_before_reset", {31'd0, busy0}, 32'd1);
      resetN = 1'b0;
      #1;
      check("midcmp_reset_best", {8'd0, best0}, 32'd0);
      check("midcmp_reset_last", {8'd0, last0}, 32'd0);
      check("midcmp_reset_flags", {28'd0, hb0, busy0, done0, nr0}, 32'd0);
      check("midcmp_reset_has_best_tie_dut", {31'd0, hb1}, 32'd0);
      @(negedge clk);
      resetN = 1'b1;

      // Capture coincident with clear: capture taken, clear ignored.
      dv = '{24'h000200, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000200};
      run_capture(dv, 1'b0);
      dv = '{24'h000300, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000200};
      run_capture(dv, 1'b0);
      do_clear();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
